seg_mux_ctrl: RTL and testbench

Parametrised, Wishbone-programmable multiplexed 7-segment display controller for the user project area. It drives up to eight time-multiplexed common-cathode/anode digits from a register file written by the management SoC. It adds programmable refresh rate, PWM brightness, per-digit blanking, decimal points, leading-zero suppression and output polarity control. It sits between the Wishbone slave port and the user GPIO pads.

---
 rtl/seg_pkg.sv | 33 +++
 rtl/seg_hex_decode.sv | 12 +
 rtl/seg_mux_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_seg_mux_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment mux controller: register map, CTRL bits,
// hex segment table and a byte-lane merge helper for Wishbone writes.
package seg_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_DIV    = 3'd1;
    localparam logic [2:0] REG_BRIGHT = 3'd2;
    localparam logic [2:0] REG_DATA   = 3'd3;
    localparam logic [2:0] REG_DP     = 3'd4;
    localparam logic [2:0] REG_BLANK  = 3'd5;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_LZS     = 1;
    localparam int CTRL_SEG_INV = 2;
    localparam int CTRL_DIG_INV = 3;

    // {g,f,e,d,c,b,a} for hex digits 0..F
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [31:0] wb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = sel[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble + decimal point to {dp,g,f,e,d,c,b,a}; zero latency, no flow control.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nib,
    input  logic       i_dp,
    output logic [7:0] o_seg
);

    assign o_seg = {i_dp, HEX_SEG[i_nib]};

endmodule

// File: rtl/seg_mux_ctrl.sv
// Wishbone-programmed multiplexed 7-segment driver; seg/dig registered one cycle after state,
// Wishbone ack one cycle after strobe with one idle cycle between back-to-back acks.
module seg_mux_ctrl
    import seg_pkg::*;
#(
    parameter int               DIGITS      = 4,
    parameter int               DIV_W       = 16,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = 16'd2499,
    parameter int               PWM_W       = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic [7:0]        seg_o,
    output logic [DIGITS-1:0] dig_o,
    output logic              frame_o
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [3:0]          r_ctrl;
    logic [DIV_W-1:0]    r_div;
    logic [PWM_W-1:0]    r_bright;
    logic [4*DIGITS-1:0] r_data;
    logic [DIGITS-1:0]   r_dp;
    logic [DIGITS-1:0]   r_blank;
    logic                r_ack;
    logic [31:0]         r_rdat;

    logic [DIV_W-1:0]    r_pre;
    logic [PWM_W-1:0]    r_pwm;
    logic [IDX_W-1:0]    r_idx;
    logic                r_run;
    logic                r_frame;
    logic [7:0]          r_seg;
    logic [DIGITS-1:0]   r_dig;

    logic                w_req;
    logic                w_wr;
    logic [2:0]          w_adr;
    logic [31:0]         w_rdata;
    logic [31:0]         w_wdat;
    logic                w_unused;

    assign w_req    = wbs_cyc_i & wbs_stb_i & ~r_ack;
    assign w_wr     = w_req & wbs_we_i;
    assign w_adr    = wbs_adr_i[4:2];
    assign w_wdat   = wb_merge(w_rdata, wbs_dat_i, wbs_sel_i);
    assign w_unused = ^{wbs_adr_i[31:5], wbs_adr_i[1:0], w_wdat};

    always_comb begin
        w_rdata = '0;
        case (w_adr)
            REG_CTRL:   w_rdata = 32'(r_ctrl);
            REG_DIV:    w_rdata = 32'(r_div);
            REG_BRIGHT: w_rdata = 32'(r_bright);
            REG_DATA:   w_rdata = 32'(r_data);
            REG_DP:     w_rdata = 32'(r_dp);
            REG_BLANK:  w_rdata = 32'(r_blank);
            default:    w_rdata = '0;
        endcase
    end

    // Writes and read capture both happen on the edge that raises ack
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_ctrl   <= '0;
            r_div    <= DEFAULT_DIV;
            r_bright <= '1;
            r_data   <= '0;
            r_dp     <= '0;
            r_blank  <= '0;
            r_ack    <= 1'b0;
            r_rdat   <= '0;
        end else begin
            r_ack  <= w_req;
            r_rdat <= w_req ? w_rdata : '0;
            if (w_wr) begin
                case (w_adr)
                    REG_CTRL:   r_ctrl   <= w_wdat[3:0];
                    REG_DIV:    r_div    <= w_wdat[DIV_W-1:0];
                    REG_BRIGHT: r_bright <= w_wdat[PWM_W-1:0];
                    REG_DATA:   r_data   <= w_wdat[4*DIGITS-1:0];
                    REG_DP:     r_dp     <= w_wdat[DIGITS-1:0];
                    REG_BLANK:  r_blank  <= w_wdat[DIGITS-1:0];
                    default:    ;
                endcase
            end
        end
    end

    logic w_en;
    logic w_tick;
    logic w_pwm_wrap;
    logic w_idx_last;

    assign w_en       = r_ctrl[CTRL_EN];
    assign w_tick     = w_en & r_run & (r_pre == '0);
    assign w_pwm_wrap = w_tick & (r_pwm == '1);
    assign w_idx_last = (r_idx == IDX_W'(DIGITS - 1));

    // r_run marks the first enabled cycle so the prescaler loads DIV before ticking
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_pre   <= '0;
            r_pwm   <= '0;
            r_idx   <= '0;
            r_run   <= 1'b0;
            r_frame <= 1'b0;
        end else if (!w_en) begin
            r_pre   <= '0;
            r_pwm   <= '0;
            r_idx   <= '0;
            r_run   <= 1'b0;
            r_frame <= 1'b0;
        end else begin
            r_run   <= 1'b1;
            r_frame <= w_pwm_wrap & w_idx_last;
            if (!r_run || r_pre == '0) r_pre <= r_div;
            else                       r_pre <= r_pre - 1'b1;
            if (w_tick)                r_pwm <= r_pwm + 1'b1;
            if (w_pwm_wrap)            r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
        end
    end

    logic [DIGITS-1:0] w_supp;
    logic              w_tail;

    // A digit is a leading zero when it and every higher digit carry no value and no dp
    always_comb begin
        w_supp = '0;
        w_tail = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_tail    = w_tail && (r_data[4*i +: 4] == 4'h0) && !r_dp[i];
            w_supp[i] = r_ctrl[CTRL_LZS] && w_tail;
        end
    end

    logic [3:0]        w_nib;
    logic              w_dp_cur;
    logic              w_blank_cur;
    logic              w_supp_cur;
    logic              w_lit;
    logic [7:0]        w_pat;
    logic [7:0]        w_seg_nxt;
    logic [DIGITS-1:0] w_dig_nxt;

    always_comb begin
        w_nib       = '0;
        w_dp_cur    = 1'b0;
        w_blank_cur = 1'b0;
        w_supp_cur  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib       = r_data[4*i +: 4];
                w_dp_cur    = r_dp[i];
                w_blank_cur = r_blank[i];
                w_supp_cur  = w_supp[i];
            end
        end
    end

    seg_hex_decode u_dec (
        .i_nib (w_nib),
        .i_dp  (w_dp_cur),
        .o_seg (w_pat)
    );

    assign w_lit     = w_en & (r_pwm < r_bright) & ~w_blank_cur & ~w_supp_cur;
    assign w_seg_nxt = (w_lit ? w_pat : 8'h00) ^ {8{r_ctrl[CTRL_SEG_INV]}};

    always_comb begin
        w_dig_nxt = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_dig_nxt[i] = (w_lit && (r_idx == IDX_W'(i))) ^ r_ctrl[CTRL_DIG_INV];
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_seg <= '0;
            r_dig <= '0;
        end else begin
            r_seg <= w_seg_nxt;
            r_dig <= w_dig_nxt;
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_rdat;
    assign seg_o     = r_seg;
    assign dig_o     = r_dig;
    assign frame_o   = r_frame;

endmodule

// File: tb/tb_seg_mux_ctrl.sv
// Bench for seg_mux_ctrl: register table, directed display configs, randomized configs vs a frame-level model.
module tb_seg_mux_ctrl;

    localparam int DIGITS = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]        sel = 4'h0;
    logic [31:0]       adr = '0, wdat = '0;
    logic              ack;
    logic [31:0]       rdat;
    logic [7:0]        seg;
    logic [DIGITS-1:0] dig;
    logic              frame;

    always #5 clk = ~clk;

    seg_mux_ctrl #(
        .DIGITS      (DIGITS),
        .DIV_W       (16),
        .DEFAULT_DIV (16'd2499),
        .PWM_W       (4)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .seg_o     (seg),
        .dig_o     (dig),
        .frame_o   (frame)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] hex_tbl [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    typedef struct {
        logic [2:0]  a;
        logic [3:0]  s;
        logic [31:0] d;
        logic [31:0] exp;
    } rv_t;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  bright;
        logic [3:0]  ctrl;
        logic [15:0] div;
        logic [DIGITS-1:0][15:0] cnt;
    } cfg_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic wb_xfer(input logic [2:0] a, input logic [3:0] s, input logic w,
                           input logic [31:0] d, output logic [31:0] q);
        int n;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = {27'b0, a, 2'b00}; wdat = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 10);
        check("wb_ack", {31'b0, ack}, 32'd1);
        q = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_wr(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] q;
        wb_xfer(a, 4'hF, 1'b1, d, q);
    endtask

    task automatic wb_rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] q;
        wb_xfer(a, 4'hF, 1'b0, 32'h0, q);
        check(name, q, exp);
    endtask

    // Lit cycles per frame follow directly from the register values
    function automatic logic [DIGITS-1:0][15:0] model_cnt(input cfg_t c);
        logic [DIGITS-1:0][15:0] res;
        logic supp;
        for (int i = 0; i < DIGITS; i++) begin
            supp = c.ctrl[1] && (i > 0) && ((c.data >> (4 * i)) == 0) && ((c.dp >> i) == 0);
            res[i] = (c.blank[i] || supp) ? 16'd0 : 16'(c.bright * (c.div + 16'd1));
        end
        return res;
    endfunction

    task automatic measure(input cfg_t c);
        int cnt [DIGITS];
        int n, cyc_n, bad;
        logic [7:0]        s;
        logic [DIGITS-1:0] dg;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame && n < 3000);
        check("frame_seen", {31'b0, frame}, 32'd1);
        for (int i = 0; i < DIGITS; i++) cnt[i] = 0;
        cyc_n = 0;
        bad   = 0;
        do begin
            @(negedge clk);
            cyc_n++;
            s  = seg ^ {8{c.ctrl[2]}};
            dg = dig ^ {DIGITS{c.ctrl[3]}};
            if (dg == '0) begin
                if (s != 8'h00) bad++;
            end else if ($countones(dg) != 1) begin
                bad++;
            end else begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (dg[i]) begin
                        cnt[i]++;
                        if (s != (hex_tbl[c.data[4*i +: 4]] | {c.dp[i], 7'b0})) bad++;
                    end
                end
            end
        end while (!frame && cyc_n < 3000);
        check("frame_period", cyc_n, 16 * DIGITS * (int'(c.div) + 1));
        for (int i = 0; i < DIGITS; i++) check($sformatf("lit_cycles_dig%0d", i), cnt[i], 32'(c.cnt[i]));
        check("pattern_errors", bad, 0);
    endtask

    task automatic run_cfg(input cfg_t c);
        wb_wr(3'd0, 32'h0);
        wb_wr(3'd3, 32'(c.data));
        wb_wr(3'd4, 32'(c.dp));
        wb_wr(3'd5, 32'(c.blank));
        wb_wr(3'd2, 32'(c.bright));
        wb_wr(3'd1, 32'(c.div));
        wb_wr(3'd0, 32'(c.ctrl));
        measure(c);
    endtask

    rv_t  rtab [13];
    cfg_t dtab [7];
    logic [31:0] rst_exp [8];

    initial begin
        logic [5:0] acks;
        cfg_t c;

        rtab[0]  = '{3'd0, 4'hF, 32'hFFFF_FFF0, 32'h0};
        rtab[1]  = '{3'd1, 4'hF, 32'h0001_2345, 32'h2345};
        rtab[2]  = '{3'd1, 4'h2, 32'h0000_AA00, 32'hAA45};
        rtab[3]  = '{3'd2, 4'hF, 32'h0000_0037, 32'h7};
        rtab[4]  = '{3'd3, 4'hF, 32'h0000_1234, 32'h1234};
        rtab[5]  = '{3'd3, 4'h1, 32'hFFFF_FFFF, 32'h12FF};
        rtab[6]  = '{3'd3, 4'hC, 32'hFFFF_FFFF, 32'h12FF};
        rtab[7]  = '{3'd4, 4'h1, 32'h0000_00FF, 32'hF};
        rtab[8]  = '{3'd5, 4'h2, 32'h0000_FFFF, 32'h0};
        rtab[9]  = '{3'd5, 4'h1, 32'h0000_0003, 32'h3};
        rtab[10] = '{3'd6, 4'hF, 32'hFFFF_FFFF, 32'h0};
        rtab[11] = '{3'd7, 4'hF, 32'hFFFF_FFFF, 32'h0};
        rtab[12] = '{3'd2, 4'h0, 32'h0000_0000, 32'h7};

        //            data      dp    blank bright ctrl  div    lit cycles {d3,d2,d1,d0}
        dtab[0] = '{16'h4321, 4'h0, 4'h0, 4'hF, 4'h1, 16'd0, {16'd15, 16'd15, 16'd15, 16'd15}};
        dtab[1] = '{16'h4321, 4'h0, 4'h0, 4'h0, 4'h1, 16'd0, {16'd0,  16'd0,  16'd0,  16'd0}};
        dtab[2] = '{16'h4321, 4'h0, 4'h0, 4'h8, 4'h1, 16'd0, {16'd8,  16'd8,  16'd8,  16'd8}};
        dtab[3] = '{16'h4321, 4'h0, 4'h0, 4'h8, 4'h1, 16'd1, {16'd16, 16'd16, 16'd16, 16'd16}};
        dtab[4] = '{16'h0005, 4'h0, 4'h0, 4'hF, 4'h3, 16'd0, {16'd0,  16'd0,  16'd0,  16'd15}};
        dtab[5] = '{16'h0005, 4'h4, 4'h0, 4'hF, 4'h3, 16'd0, {16'd0,  16'd15, 16'd15, 16'd15}};
        dtab[6] = '{16'h4321, 4'h0, 4'h2, 4'hF, 4'hD, 16'd0, {16'd15, 16'd15, 16'd0,  16'd15}};

        rst_exp = '{32'h0, 32'd2499, 32'hF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

        repeat (3) @(negedge clk);
        check("rst_seg", 32'(seg), 32'h0);
        check("rst_dig", 32'(dig), 32'h0);
        check("rst_frame", 32'(frame), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_dat", rdat, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) wb_rd_check($sformatf("reset_reg%0d", i), 3'(i), rst_exp[i]);

        for (int i = 0; i < 13; i++) begin
            logic [31:0] q;
            wb_xfer(rtab[i].a, rtab[i].s, 1'b1, rtab[i].d, q);
            wb_rd_check($sformatf("regtab%0d", i), rtab[i].a, rtab[i].exp);
        end

        // Strobe held continuously: acks alternate with idle cycles
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0;
        acks = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            acks = {acks[4:0], ack};
        end
        cyc = 1'b0; stb = 1'b0;
        check("ack_throughput", 32'(acks), 32'b101010);

        // Both inversions with EN=0: outputs sit at inactive levels
        wb_wr(3'd0, 32'h0000_000C);
        repeat (2) @(negedge clk);
        check("inv_idle_seg", 32'(seg), 32'hFF);
        check("inv_idle_dig", 32'(dig), 32'hF);
        wb_wr(3'd0, 32'h0);

        for (int i = 0; i < 7; i++) run_cfg(dtab[i]);

        for (int k = 0; k < 8; k++) begin
            c.data = '0;
            for (int i = 0; i < DIGITS; i++)
                if ($urandom_range(0, 1) == 1) c.data[4*i +: 4] = 4'($urandom_range(0, 15));
            c.dp     = 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
            c.blank  = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            c.bright = 4'($urandom_range(0, 15));
            c.ctrl   = {2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1};
            c.div    = 16'($urandom_range(0, 2));
            c.cnt    = model_cnt(c);
            run_cfg(c);
        end

        // Reset asserted in the middle of an active scan
        run_cfg(dtab[0]);
        repeat (37) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midscan_rst_seg", 32'(seg), 32'h0);
        check("midscan_rst_dig", 32'(dig), 32'h0);
        check("midscan_rst_frame", 32'(frame), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wb_rd_check("midscan_rst_ctrl", 3'd0, 32'h0);
        wb_rd_check("midscan_rst_div", 3'd1, 32'd2499);
        repeat (3) @(negedge clk);
        check("midscan_idle_dig", 32'(dig), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
